// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// Receive FIFO behind a UART receiver: first-word-fall-through output,
// hysteretic RTS flow control, and sticky overflow / saturating drop counter.
module uart_rx_fifo #(
    parameter int WORD_SIZE  = 8,
    parameter int DEPTH      = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WORD_SIZE-1:0]       wr_data,
    input  logic                       wr_pulse,
    output logic [WORD_SIZE-1:0]       rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       rts_n,
    output logic                       overflow,
    input  logic                       overflow_clr,
    output logic [7:0]                 drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] RTS_ON  = CW'(RTS_MARGIN);
    localparam logic [CW-1:0] RTS_OFF = CW'(2 * RTS_MARGIN);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        free_d;
    logic                 rts_n_q, rts_n_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           drop_count_q, drop_count_d;
    logic                 push, pop, drop;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign rd_valid = !empty;
    assign rd_data  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same edge, so a full FIFO still accepts a push alongside it.
    assign pop  = rd_valid && rd_ready;
    assign push = wr_pulse && (!full || pop);
    assign drop = wr_pulse && full && !pop;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        rts_n_d      = rts_n_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop)              overflow_d = 1'b1;
        else if (overflow_clr) overflow_d = 1'b0;

        if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;

        // Threshold on the post-edge occupancy; between the two levels hold the last value.
        free_d = DEPTH_C - count_d;
        if (free_d <= RTS_ON)       rts_n_d = 1'b1;
        else if (free_d >= RTS_OFF) rts_n_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rts_n_q      <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rts_n_q      <= rts_n_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign count      = count_q;
    assign rts_n      = rts_n_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
endmodule
